porta_contador: RTL and testbench
=================================

# porta_contador

Occupancy monitor at the far end of the turnstile door controller. It consumes the controller's passage and metal-alarm indications as levels, and converts their rising edges into a saturating occupancy count. It shows that count as two decimal digits, latches metal alarms until the operator acknowledges them, and drives admission, full and alarm lamps.

## Interface
- CAPACITY, 99: maximum occupancy. Legal range 1..99.
- ALARM_HOLD, 8: minimum number of clock cycles an alarm stays latched before ACK is honoured. Legal range 1..255.

- KEY[0]  in  1  clock; all state changes on its rising edge.
- KEY[1]  in  1  reset; synchronous, active-high.
- ENTRY  in  1  level; high while the door controller grants an entry passage.
- EXIT  in  1  level; high while the door controller grants an exit passage.
- ALARM  in  1  level; high while the metal sensor path is active.
- ACK  in  1  level; operator acknowledge for a latched alarm.
- HEX0  out  [0:6]  units digit of occupancy; active-low, bit 0 = segment a … bit 6 = segment g.
- HEX1  out  [0:6]  tens digit; blank (1111111) when occupancy < 10.
- HEX2  out  [0:6]  status letter: A = 0001000 in ALARME, L = 1110001 in LOTADO, blank in LIVRE.
- LEDG  out  1  admission allowed; high only in LIVRE.
- LEDR  out  [1:0]  LEDR[0] = alarm latched; LEDR[1] = occupancy equals CAPACITY.

## Operation
- Edge detection:
  - One previous-sample register each for ENTRY, EXIT and ALARM.
  - An event is input = 1 with previous sample = 0.
  - During reset, each previous-sample register loads the current input, so a level held through reset is never counted.
- Occupancy count: 7-bit unsigned, range 0..CAPACITY.
  - Entry event: +1 if count < CAPACITY and state ≠ ALARME. Otherwise ignored; the count saturates.
  - Exit event: −1 if count > 0, in any state. At 0 it is ignored.
  - Entry and exit events in the same cycle, both accepted: the count is unchanged.
  - Same cycle with the entry rejected (full or ALARME): only the exit applies.
- Digit encodings, 0..9: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100.
  - HEX0 = count mod 10. HEX1 = count div 10, with leading zero suppressed.
- States:
  - LIVRE: count < CAPACITY.
  - LOTADO: count = CAPACITY.
  - ALARME: alarm latched.
- Transitions:
  - Any state → ALARME on an alarm event. Highest priority; it also loads the hold counter with ALARM_HOLD.
  - LIVRE ↔ LOTADO follows the count after the update in the same cycle.
  - ALARME → LIVRE/LOTADO when all three hold: ACK = 1, ALARM = 0, hold counter = 0. The target is chosen by the current count.
  - While latched, ACK with ALARM still high or hold counter > 0 is ignored. No pending acknowledge is remembered.
  - A new alarm event while in ALARME reloads the hold counter.
- Outputs are decoded combinationally from registered state and count only; there is no input-to-output combinational path.

## Timing
- Reset values after the reset edge: count 0, state LIVRE, hold counter 0, HEX0 = 0000001, HEX1 = 1111111, HEX2 = 1111111, LEDG = 1, LEDR = 00.
- Reset mid-operation discards the count and any latched alarm on that edge.
- Latency:
  - An input first sampled high at edge n updates count/state at edge n.
  - Outputs reflect the update immediately after edge n.
- Hold counter:
  - Decrements once per cycle while in ALARME and > 0.
  - The earliest honoured ACK is at edge n + ALARM_HOLD + 1, where n is the alarm event edge.
- Inputs stay high for several cycles per passage, but each passage counts exactly once. A re-count requires an intervening low sample.
- Inputs are synchronous to KEY[0]; there is no internal synchroniser.

## Test plan
- Reset, then 3 entry pulses, each high for 4 cycles → HEX0 = 0000110, HEX1 = 1111111, LEDG = 1, LEDR = 00.
- Count 9, then 1 entry pulse → HEX1 = 1001111, HEX0 = 0000001 (10). Then 10 exit pulses plus 1 extra → count 0, and no underflow on the extra exit.
- CAPACITY = 3: 4 entry pulses → count 3, HEX2 = 1110001, LEDG = 0, LEDR[1] = 1. Then 1 exit → LIVRE, LEDG = 1, LEDR[1] = 0.
- Count 5: ENTRY and EXIT rise in the same cycle → count stays 5. Count 3 (full, CAPACITY = 3), same simultaneous rise → count 2.
- Alarm with ALARM_HOLD = 8:
  - Alarm event at edge n → LEDR[0] = 1, HEX2 = 0001000, LEDG = 0.
  - An entry pulse during the alarm is not counted; an exit pulse is counted.
  - ACK at n + 3 is ignored. ACK with ALARM high is ignored.
  - ALARM low and ACK at n + 9 → returns to LIVRE.
- ENTRY held high across reset assertion and release → count stays 0. Reset asserted during ALARME → LEDR = 00, HEX0 = 0000001 on the next edge.

Source files
------------

// File: rtl/porta_contador.sv
// Occupancy monitor: turns passage/alarm level edges into a saturating head
// count, latches metal alarms until acknowledged, and drives 7-seg and lamps.
module porta_contador #(
  parameter int CAPACITY   = 99,
  parameter int ALARM_HOLD = 8
) (
  input  logic [1:0] KEY,
  input  logic       ENTRY,
  input  logic       EXIT,
  input  logic       ALARM,
  input  logic       ACK,
  output logic [0:6] HEX0,
  output logic [0:6] HEX1,
  output logic [0:6] HEX2,
  output logic       LEDG,
  output logic [1:0] LEDR
);

  typedef enum logic [1:0] {
    LIVRE  = 2'd0,
    LOTADO = 2'd1,
    ALARME = 2'd2
  } state_t;

  localparam logic [6:0] CAP       = 7'(CAPACITY);
  localparam logic [7:0] HOLD_INIT = 8'(ALARM_HOLD);
  localparam logic [6:0] BLANK     = 7'b1111111;

  logic clk;
  logic srst;
  assign clk  = KEY[0];
  assign srst = KEY[1];

  // bit 0 = ENTRY, bit 1 = EXIT, bit 2 = ALARM
  logic [2:0] lvl;
  logic [2:0] ev;
  assign lvl = {ALARM, EXIT, ENTRY};

  // The previous sample follows the input during reset as well, so a level
  // held high through reset never produces an event afterwards.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_edge
      logic prev_reg;
      always_ff @(posedge clk) begin
        prev_reg <= lvl[gi];
      end
      assign ev[gi] = lvl[gi] & ~prev_reg;
    end
  endgenerate

  state_t     state_reg, state_next;
  logic [6:0] count_reg, count_next;
  logic [7:0] hold_reg,  hold_next;
  logic       entry_ok;
  logic       exit_ok;
  logic       ack_ok;

  always_comb begin
    entry_ok = ev[0] && (count_reg < CAP) && (state_reg != ALARME);
    exit_ok  = ev[1] && (count_reg != 7'd0);
    ack_ok   = ACK && !ALARM && (hold_reg == 8'd0);

    count_next = count_reg;
    if (entry_ok && !exit_ok) begin
      count_next = count_reg + 7'd1;
    end else if (exit_ok && !entry_ok) begin
      count_next = count_reg - 7'd1;
    end

    hold_next = hold_reg;
    if (ev[2]) begin
      hold_next = HOLD_INIT;
    end else if (state_reg == ALARME && hold_reg != 8'd0) begin
      hold_next = hold_reg - 8'd1;
    end

    // A fresh alarm edge wins over everything, including a valid acknowledge.
    state_next = state_reg;
    if (ev[2]) begin
      state_next = ALARME;
    end else if (state_reg != ALARME || ack_ok) begin
      state_next = (count_next == CAP) ? LOTADO : LIVRE;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg <= LIVRE;
      count_reg <= 7'd0;
      hold_reg  <= 8'd0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      hold_reg  <= hold_next;
    end
  end

  function automatic logic [6:0] seg7(input logic [6:0] d);
    case (d)
      7'd0:    seg7 = 7'b0000001;
      7'd1:    seg7 = 7'b1001111;
      7'd2:    seg7 = 7'b0010010;
      7'd3:    seg7 = 7'b0000110;
      7'd4:    seg7 = 7'b1001100;
      7'd5:    seg7 = 7'b0100100;
      7'd6:    seg7 = 7'b0100000;
      7'd7:    seg7 = 7'b0001111;
      7'd8:    seg7 = 7'b0000000;
      7'd9:    seg7 = 7'b0000100;
      default: seg7 = BLANK;
    endcase
  endfunction

  logic [6:0] units;
  logic [6:0] tens;

  // Display and lamps depend on registered state only.
  always_comb begin
    units = count_reg % 7'd10;
    tens  = count_reg / 7'd10;
    HEX0  = seg7(units);
    HEX1  = (count_reg < 7'd10) ? BLANK : seg7(tens);
    case (state_reg)
      ALARME:  HEX2 = 7'b0001000;
      LOTADO:  HEX2 = 7'b1110001;
      default: HEX2 = BLANK;
    endcase
    LEDG    = (state_reg == LIVRE);
    LEDR[0] = (state_reg == ALARME);
    LEDR[1] = (count_reg == CAP);
  end

endmodule

// File: tb/tb_porta_contador.sv
// Directed bench for porta_contador: stimulus pushes expected occupancy/state
// into a queue, a negedge monitor pops and compares the displayed outputs.
module tb_porta_contador;

  logic clk;
  logic rst;
  logic e99, x99, a99, k99;
  logic e3,  x3,  a3,  k3;
  logic [0:6] h0_99, h1_99, h2_99, h0_3, h1_3, h2_3;
  logic       g99, g3;
  logic [1:0] r99, r3;

  porta_contador #(.CAPACITY(99), .ALARM_HOLD(8)) dut (
    .KEY({rst, clk}), .ENTRY(e99), .EXIT(x99), .ALARM(a99), .ACK(k99),
    .HEX0(h0_99), .HEX1(h1_99), .HEX2(h2_99), .LEDG(g99), .LEDR(r99)
  );

  porta_contador #(.CAPACITY(3), .ALARM_HOLD(8)) dut3 (
    .KEY({rst, clk}), .ENTRY(e3), .EXIT(x3), .ALARM(a3), .ACK(k3),
    .HEX0(h0_3), .HEX1(h1_3), .HEX2(h2_3), .LEDG(g3), .LEDR(r3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int    dut;
    string name;
    int    cnt;
    int    st;   // 0 LIVRE, 1 LOTADO, 2 ALARME
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  logic [6:0] seg_tab [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100};

  always @(negedge clk) begin : mon
    exp_t       e;
    int         cap;
    logic [0:6] eh0, eh1, eh2;
    logic       eg;
    logic [1:0] er;
    logic [23:0] act, req;
    while (q.size() > 0) begin
      e   = q.pop_front();
      cap = (e.dut == 1) ? 3 : 99;
      eh0 = seg_tab[e.cnt % 10];
      eh1 = (e.cnt < 10) ? 7'b1111111 : seg_tab[e.cnt / 10];
      eh2 = (e.st == 2) ? 7'b0001000 : (e.st == 1) ? 7'b1110001 : 7'b1111111;
      eg  = (e.st == 0);
      er  = {e.cnt == cap, e.st == 2};
      req = {eh0, eh1, eh2, eg, er};
      act = (e.dut == 1) ? {h0_3, h1_3, h2_3, g3, r3} : {h0_99, h1_99, h2_99, g99, r99};
      checks++;
      if (act !== req) begin
        errors++;
        $display("FAIL %s: actual=%b required=%b", e.name, act, req);
      end else begin
        $display("ok   %s: hex0/hex1/hex2/ledg/ledr=%b", e.name, act);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic setsig(input int d, input int s, input logic v);
    if (d == 0) begin
      case (s)
        0: e99 = v;
        1: x99 = v;
        2: a99 = v;
        default: k99 = v;
      endcase
    end else begin
      case (s)
        0: e3 = v;
        1: x3 = v;
        2: a3 = v;
        default: k3 = v;
      endcase
    end
  endtask

  task automatic pulse(input int d, input int s, input int w);
    setsig(d, s, 1'b1);
    tick(w);
    setsig(d, s, 1'b0);
    tick(1);
  endtask

  task automatic chk(input int d, input string nm, input int c, input int st);
    exp_t e;
    e.dut  = d;
    e.name = nm;
    e.cnt  = c;
    e.st   = st;
    q.push_back(e);
  endtask

  initial begin
    rst = 1'b1;
    {e99, x99, a99, k99, e3, x3, a3, k3} = '0;
    tick(2);
    chk(0, "reset99", 0, 0);
    chk(1, "reset3", 0, 0);
    rst = 1'b0;

    // counting and decimal display
    repeat (3) pulse(0, 0, 4);
    chk(0, "three_entries", 3, 0);
    repeat (6) pulse(0, 0, 2);
    chk(0, "count9", 9, 0);
    pulse(0, 0, 1);
    chk(0, "count10", 10, 0);
    repeat (10) pulse(0, 1, 3);
    chk(0, "back_to_0", 0, 0);
    pulse(0, 1, 2);
    chk(0, "no_underflow", 0, 0);
    repeat (5) pulse(0, 0, 1);
    chk(0, "count5", 5, 0);
    setsig(0, 0, 1'b1); setsig(0, 1, 1'b1);
    tick(1);
    chk(0, "simul_at5", 5, 0);
    setsig(0, 0, 1'b0); setsig(0, 1, 1'b0);
    tick(1);
    chk(0, "after_simul", 5, 0);

    // small capacity: saturation and LOTADO
    repeat (3) pulse(1, 0, 2);
    chk(1, "cap3_full", 3, 1);
    pulse(1, 0, 2);
    chk(1, "cap3_saturate", 3, 1);
    pulse(1, 1, 2);
    chk(1, "cap3_exit", 2, 0);
    pulse(1, 0, 2);
    chk(1, "cap3_refill", 3, 1);
    setsig(1, 0, 1'b1); setsig(1, 1, 1'b1);
    tick(1);
    chk(1, "cap3_simul_full", 2, 0);
    setsig(1, 0, 1'b0); setsig(1, 1, 1'b0);
    tick(1);

    // alarm episode with ALARM held high
    setsig(0, 2, 1'b1);
    tick(1);                              // edge n
    chk(0, "alarm_event", 5, 2);
    pulse(0, 0, 1);                       // edges n+1, n+2
    chk(0, "entry_in_alarm", 5, 2);
    setsig(0, 3, 1'b1);
    tick(1);                              // n+3
    setsig(0, 3, 1'b0);
    chk(0, "ack_n3_ignored", 5, 2);
    pulse(0, 1, 1);                       // n+4, n+5
    chk(0, "exit_in_alarm", 4, 2);
    tick(4);                              // n+9
    setsig(0, 3, 1'b1);
    tick(1);                              // n+10, ALARM still high
    chk(0, "ack_alarm_high", 4, 2);
    setsig(0, 2, 1'b0);
    tick(1);
    setsig(0, 3, 1'b0);
    chk(0, "ack_release", 4, 0);

    // alarm episode with a one-cycle alarm: hold boundary
    setsig(0, 2, 1'b1);
    tick(1);                              // edge m
    setsig(0, 2, 1'b0);
    chk(0, "alarm2_event", 4, 2);
    tick(7);
    setsig(0, 3, 1'b1);
    tick(1);                              // m+8
    chk(0, "ack_n8_ignored", 4, 2);
    tick(1);                              // m+9
    setsig(0, 3, 1'b0);
    chk(0, "ack_n9_honoured", 4, 0);

    // reset while alarmed
    setsig(0, 2, 1'b1);
    tick(1);
    setsig(0, 2, 1'b0);
    chk(0, "alarm3_event", 4, 2);
    rst = 1'b1;
    tick(1);
    chk(0, "reset_in_alarm", 0, 0);
    chk(1, "reset_dut3", 0, 0);
    rst = 1'b0;

    // ENTRY held through reset is not counted
    setsig(0, 0, 1'b1);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(3);
    chk(0, "held_through_reset", 0, 0);
    setsig(0, 0, 1'b0);
    tick(1);
    chk(0, "held_released", 0, 0);
    pulse(0, 0, 2);
    chk(0, "first_after_reset", 1, 0);

    tick(2);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: actual=%0d pending required=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
